// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control unit.
package mips_ctrl_pkg;

    // Controller states. The encoding is visible on state_o for debug.
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11,
        ST_ILLEGAL   = 4'd12
    } state_e;

    // Primary opcodes (IR[31:26]) recognised by the controller.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU input B select.
    typedef enum logic [1:0] {
        SRCB_B       = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    // Next-PC select.
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_source_e;

    // ALU operation class handed to the ALU control block.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Full control vector driven into the datapath.
    typedef struct packed {
        logic       reg_dst;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        pc_source_e pc_source;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // A memory access finishes this cycle when there is no handshake
    // (single-cycle memory) or when the memory reports ready.
    function automatic logic mem_access_done(input logic handshake, input logic ready);
        return !handshake || ready;
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decode: current state (plus mem_ready in memory states and
// opcode in BRANCH) to the datapath control vector. Purely combinational.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 0
) (
    input  state_e     state_i,
    input  logic       mem_ready_i,
    input  logic [5:0] opcode_i,
    output ctrl_t      ctrl_o
);

    logic mem_done;

    assign mem_done = mem_access_done(MEM_HANDSHAKE != 0, mem_ready_i);

    // Per-state control decode; anything not set for a state stays 0.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC only update on the cycle the read completes, so a
                // stalled fetch keeps re-reading the same address.
                ctrl_o.ir_write  = mem_done;
                ctrl_o.pc_write  = mem_done;
            end
            ST_DECODE: begin
                // Speculative branch target: PC + (signext << 2).
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_done;
            end
            ST_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.branch_ne     = (opcode_i == OP_BNE);
                ctrl_o.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            ST_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ST_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.instr_done = 1'b1;
            end
            ST_ILLEGAL: begin
                ctrl_o.illegal_op = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM. Holds the state register and next-state
// logic; output decode lives in mips_ctrl_outdec. While reset is high every
// output is forced low so nothing in the datapath can be written.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 0,
    parameter int ENABLE_BNE    = 1,
    parameter int ALUOP_W       = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               reg_dst,
    output logic               i_or_d,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [3:0]         state_o
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl;
    logic   mem_done;

    assign mem_done = mem_access_done(MEM_HANDSHAKE != 0, mem_ready);

    // State register; reset returns to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Memory states hold until the access completes;
    // ILLEGAL is absorbing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_done) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_R_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_BNE:       state_d = (ENABLE_BNE != 0) ? ST_BRANCH : ST_ILLEGAL;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEM_ADDR:  state_d = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ: begin
                if (mem_done) state_d = ST_MEM_WB;
            end
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: begin
                if (mem_done) state_d = ST_FETCH;
            end
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_R_WB:      state_d = ST_FETCH;
            ST_BRANCH:    state_d = ST_FETCH;
            ST_JUMP:      state_d = ST_FETCH;
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            ST_ADDI_WB:   state_d = ST_FETCH;
            ST_ILLEGAL:   state_d = ST_ILLEGAL;
            default:      state_d = ST_FETCH;
        endcase
    end

    mips_ctrl_outdec #(
        .MEM_HANDSHAKE(MEM_HANDSHAKE)
    ) u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .opcode_i    (opcode),
        .ctrl_o      (ctrl_raw)
    );

    // Reset gates the outputs combinationally so they drop the moment reset
    // rises, not at the next clock edge.
    always_comb begin
        ctrl = reset ? '0 : ctrl_raw;
    end

    assign reg_dst       = ctrl.reg_dst;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ALUOP_W'(ctrl.alu_op);
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_write     = ctrl.reg_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign instr_done    = ctrl.instr_done;
    assign illegal_op    = ctrl.illegal_op;
    assign state_o       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl. dut0: single-cycle memory, bne enabled.
// dut1: memory handshake, bne disabled. Each cycle's expected control vector
// is queued with the mem_ready value to drive, then popped and compared.
module tb_mips_multicycle_ctrl;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3,
                   S_MEM_WB = 4, S_MEM_WRITE = 5, S_R_EXEC = 6, S_R_WB = 7,
                   S_BRANCH = 8, S_JUMP = 9, S_ADDI_EXEC = 10, S_ADDI_WB = 11,
                   S_ILLEGAL = 12;

    localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_BEQ = 6'b000100,
                           O_BNE = 6'b000101, O_ADDI = 6'b001000,
                           O_LW = 6'b100011, O_SW = 6'b101011;

    typedef struct packed {
        logic       reg_dst;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       instr_done;
        logic       illegal_op;
        logic [3:0] state;
    } ctl_t;

    typedef struct packed {
        logic rdy;
        ctl_t exp;
    } sb_t;

    logic clk;
    logic reset0, reset1;
    logic [5:0] op0, op1;
    logic rdy0, rdy1;

    logic       d0_reg_dst, d0_i_or_d, d0_mem_to_reg, d0_alu_src_a;
    logic [1:0] d0_alu_src_b, d0_pc_source, d0_alu_op;
    logic       d0_mem_read, d0_mem_write, d0_ir_write, d0_reg_write, d0_pc_write;
    logic       d0_pc_write_cond, d0_branch_ne, d0_instr_done, d0_illegal_op;
    logic [3:0] d0_state;

    logic       d1_reg_dst, d1_i_or_d, d1_mem_to_reg, d1_alu_src_a;
    logic [1:0] d1_alu_src_b, d1_pc_source, d1_alu_op;
    logic       d1_mem_read, d1_mem_write, d1_ir_write, d1_reg_write, d1_pc_write;
    logic       d1_pc_write_cond, d1_branch_ne, d1_instr_done, d1_illegal_op;
    logic [3:0] d1_state;

    int n_checks = 0;
    int n_pass   = 0;
    sb_t q[$];

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(0), .ENABLE_BNE(1), .ALUOP_W(2)) dut0 (
        .clk(clk), .reset(reset0), .opcode(op0), .mem_ready(rdy0),
        .reg_dst(d0_reg_dst), .i_or_d(d0_i_or_d), .mem_to_reg(d0_mem_to_reg),
        .alu_src_a(d0_alu_src_a), .alu_src_b(d0_alu_src_b), .pc_source(d0_pc_source),
        .alu_op(d0_alu_op), .mem_read(d0_mem_read), .mem_write(d0_mem_write),
        .ir_write(d0_ir_write), .reg_write(d0_reg_write), .pc_write(d0_pc_write),
        .pc_write_cond(d0_pc_write_cond), .branch_ne(d0_branch_ne),
        .instr_done(d0_instr_done), .illegal_op(d0_illegal_op), .state_o(d0_state)
    );

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1), .ENABLE_BNE(0), .ALUOP_W(2)) dut1 (
        .clk(clk), .reset(reset1), .opcode(op1), .mem_ready(rdy1),
        .reg_dst(d1_reg_dst), .i_or_d(d1_i_or_d), .mem_to_reg(d1_mem_to_reg),
        .alu_src_a(d1_alu_src_a), .alu_src_b(d1_alu_src_b), .pc_source(d1_pc_source),
        .alu_op(d1_alu_op), .mem_read(d1_mem_read), .mem_write(d1_mem_write),
        .ir_write(d1_ir_write), .reg_write(d1_reg_write), .pc_write(d1_pc_write),
        .pc_write_cond(d1_pc_write_cond), .branch_ne(d1_branch_ne),
        .instr_done(d1_instr_done), .illegal_op(d1_illegal_op), .state_o(d1_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t obs0();
        ctl_t c;
        c = '{d0_reg_dst, d0_i_or_d, d0_mem_to_reg, d0_alu_src_a, d0_alu_src_b,
              d0_pc_source, d0_alu_op, d0_mem_read, d0_mem_write, d0_ir_write,
              d0_reg_write, d0_pc_write, d0_pc_write_cond, d0_branch_ne,
              d0_instr_done, d0_illegal_op, d0_state};
        return c;
    endfunction

    function automatic ctl_t obs1();
        ctl_t c;
        c = '{d1_reg_dst, d1_i_or_d, d1_mem_to_reg, d1_alu_src_a, d1_alu_src_b,
              d1_pc_source, d1_alu_op, d1_mem_read, d1_mem_write, d1_ir_write,
              d1_reg_write, d1_pc_write, d1_pc_write_cond, d1_branch_ne,
              d1_instr_done, d1_illegal_op, d1_state};
        return c;
    endfunction

    // Expected Moore outputs for a state, written from the control table.
    function automatic ctl_t exp_ctl(int st, logic rdy, logic hs, logic [5:0] op);
        ctl_t c;
        logic done;
        c = '0;
        done = !hs || rdy;
        c.state = 4'(st);
        case (st)
            S_FETCH:     begin c.mem_read = 1; c.alu_src_b = 2'b01;
                               c.ir_write = done; c.pc_write = done; end
            S_DECODE:    c.alu_src_b = 2'b11;
            S_MEM_ADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MEM_READ:  begin c.mem_read = 1; c.i_or_d = 1; end
            S_MEM_WB:    begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
            S_MEM_WRITE: begin c.mem_write = 1; c.i_or_d = 1; c.instr_done = done; end
            S_R_EXEC:    begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            S_R_WB:      begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
            S_BRANCH:    begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                               c.pc_source = 2'b01; c.branch_ne = (op == O_BNE);
                               c.instr_done = 1; end
            S_JUMP:      begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
            S_ADDI_EXEC: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_ADDI_WB:   begin c.reg_write = 1; c.instr_done = 1; end
            S_ILLEGAL:   c.illegal_op = 1;
            default:     ;
        endcase
        return c;
    endfunction

    function automatic void push(int st, logic rdy, logic hs, logic [5:0] op);
        sb_t e;
        e.rdy = rdy;
        e.exp = exp_ctl(st, rdy, hs, op);
        q.push_back(e);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic test_reset();
        ctl_t got;
        reset0 = 1; reset1 = 1; op0 = O_LW; op1 = O_LW; rdy0 = 1; rdy1 = 1;
        #3;
        got = obs0(); n_checks++;
        if (got !== '0) $display("FAIL reset_d0: got %h exp %h", got, ctl_t'('0));
        else n_pass++;
        got = obs1(); n_checks++;
        if (got !== '0) $display("FAIL reset_d1: got %h exp %h", got, ctl_t'('0));
        else n_pass++;
        @(posedge clk); #1;
        got = obs0(); n_checks++;
        if (got !== '0) $display("FAIL reset_hold_d0: got %h exp %h", got, ctl_t'('0));
        else n_pass++;
        got = obs1(); n_checks++;
        if (got !== '0) $display("FAIL reset_hold_d1: got %h exp %h", got, ctl_t'('0));
        else n_pass++;
        reset0 = 0;
    endtask

    task automatic test_lw();
        sb_t e; ctl_t got; int i;
        op0 = O_LW;
        push(S_FETCH, rnd(), 0, O_LW);    push(S_DECODE, rnd(), 0, O_LW);
        push(S_MEM_ADDR, rnd(), 0, O_LW); push(S_MEM_READ, rnd(), 0, O_LW);
        push(S_MEM_WB, rnd(), 0, O_LW);
        i = 1;
        while (q.size() > 0) begin
            e = q.pop_front(); rdy0 = e.rdy;
            @(negedge clk); got = obs0(); n_checks++;
            if (got !== e.exp) $display("FAIL lw cyc%0d: got %h exp %h", i, got, e.exp);
            else n_pass++;
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_back_to_back();
        sb_t e; ctl_t got; int i;
        push(S_FETCH, rnd(), 0, O_R);  push(S_DECODE, rnd(), 0, O_R);
        push(S_R_EXEC, rnd(), 0, O_R); push(S_R_WB, rnd(), 0, O_R);
        push(S_FETCH, rnd(), 0, O_ADDI);     push(S_DECODE, rnd(), 0, O_ADDI);
        push(S_ADDI_EXEC, rnd(), 0, O_ADDI); push(S_ADDI_WB, rnd(), 0, O_ADDI);
        i = 1;
        while (q.size() > 0) begin
            e = q.pop_front(); rdy0 = e.rdy;
            op0 = (i <= 4) ? O_R : O_ADDI;
            @(negedge clk); got = obs0(); n_checks++;
            if (got !== e.exp) $display("FAIL r_addi cyc%0d: got %h exp %h", i, got, e.exp);
            else n_pass++;
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_branch();
        sb_t e; ctl_t got; int i;
        push(S_FETCH, rnd(), 0, O_BEQ); push(S_DECODE, rnd(), 0, O_BEQ);
        push(S_BRANCH, rnd(), 0, O_BEQ);
        push(S_FETCH, rnd(), 0, O_BNE); push(S_DECODE, rnd(), 0, O_BNE);
        push(S_BRANCH, rnd(), 0, O_BNE);
        i = 1;
        while (q.size() > 0) begin
            e = q.pop_front(); rdy0 = e.rdy;
            op0 = (i <= 3) ? O_BEQ : O_BNE;
            @(negedge clk); got = obs0(); n_checks++;
            if (got !== e.exp) $display("FAIL beq_bne cyc%0d: got %h exp %h", i, got, e.exp);
            else n_pass++;
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_jump();
        sb_t e; ctl_t got; int i;
        op0 = O_J;
        push(S_FETCH, rnd(), 0, O_J); push(S_DECODE, rnd(), 0, O_J);
        push(S_JUMP, rnd(), 0, O_J);  push(S_FETCH, rnd(), 0, O_J);
        i = 1;
        while (q.size() > 0) begin
            e = q.pop_front(); rdy0 = e.rdy;
            @(negedge clk); got = obs0(); n_checks++;
            if (got !== e.exp) $display("FAIL jump cyc%0d: got %h exp %h", i, got, e.exp);
            else n_pass++;
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_fetch_wait();
        sb_t e; ctl_t got; int i;
        reset1 = 0; op1 = O_R;
        push(S_FETCH, 0, 1, O_R); push(S_FETCH, 0, 1, O_R); push(S_FETCH, 1, 1, O_R);
        push(S_DECODE, rnd(), 1, O_R); push(S_R_EXEC, rnd(), 1, O_R);
        push(S_R_WB, rnd(), 1, O_R);
        i = 1;
        while (q.size() > 0) begin
            e = q.pop_front(); rdy1 = e.rdy;
            @(negedge clk); got = obs1(); n_checks++;
            if (got !== e.exp) $display("FAIL fetch_wait cyc%0d: got %h exp %h", i, got, e.exp);
            else n_pass++;
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_sw_wait();
        sb_t e; ctl_t got; int i;
        op1 = O_SW;
        push(S_FETCH, 1, 1, O_SW); push(S_DECODE, rnd(), 1, O_SW);
        push(S_MEM_ADDR, rnd(), 1, O_SW);
        push(S_MEM_WRITE, 0, 1, O_SW); push(S_MEM_WRITE, 0, 1, O_SW);
        push(S_MEM_WRITE, 0, 1, O_SW); push(S_MEM_WRITE, 1, 1, O_SW);
        i = 1;
        while (q.size() > 0) begin
            e = q.pop_front(); rdy1 = e.rdy;
            @(negedge clk); got = obs1(); n_checks++;
            if (got !== e.exp) $display("FAIL sw_wait cyc%0d: got %h exp %h", i, got, e.exp);
            else n_pass++;
            @(posedge clk); #1; i++;
        end
    endtask

    task automatic test_illegal();
        sb_t e; ctl_t got; int i;
        op1 = O_BNE;
        push(S_FETCH, 1, 1, O_BNE); push(S_DECODE, rnd(), 1, O_BNE);
        for (int k = 0; k < 20; k++) push(S_ILLEGAL, rnd(), 1, O_BNE);
        i = 1;
        while (q.size() > 0) begin
            e = q.pop_front(); rdy1 = e.rdy;
            if (i > 2) op1 = O_LW;
            @(negedge clk); got = obs1(); n_checks++;
            if (got !== e.exp) $display("FAIL illegal cyc%0d: got %h exp %h", i, got, e.exp);
            else n_pass++;
            @(posedge clk); #1; i++;
        end
        reset1 = 1; #1;
        got = obs1(); n_checks++;
        if (got !== '0) $display("FAIL illegal_reset: got %h exp %h", got, ctl_t'('0));
        else n_pass++;
        @(posedge clk); #1;
        reset1 = 0;
    endtask

    task automatic test_reset_mid();
        sb_t e; ctl_t got; int i;
        op1 = O_LW;
        push(S_FETCH, 1, 1, O_LW); push(S_DECODE, rnd(), 1, O_LW);
        push(S_MEM_ADDR, rnd(), 1, O_LW);
        push(S_MEM_READ, 0, 1, O_LW); push(S_MEM_READ, 0, 1, O_LW);
        i = 1;
        while (q.size() > 0) begin
            e = q.pop_front(); rdy1 = e.rdy;
            @(negedge clk); got = obs1(); n_checks++;
            if (got !== e.exp) $display("FAIL rst_mid_pre cyc%0d: got %h exp %h", i, got, e.exp);
            else n_pass++;
            @(posedge clk); #1; i++;
        end
        // Still waiting in MEM_READ; reset lands mid-cycle with ready high.
        #2; reset1 = 1; rdy1 = 1; #1;
        got = obs1(); n_checks++;
        if (got !== '0) $display("FAIL rst_mid_async: got %h exp %h", got, ctl_t'('0));
        else n_pass++;
        @(posedge clk); #1;
        got = obs1(); n_checks++;
        if (got !== '0) $display("FAIL rst_mid_hold: got %h exp %h", got, ctl_t'('0));
        else n_pass++;
        reset1 = 0;
        push(S_FETCH, 0, 1, O_LW); push(S_FETCH, 1, 1, O_LW);
        push(S_DECODE, rnd(), 1, O_LW); push(S_MEM_ADDR, rnd(), 1, O_LW);
        push(S_MEM_READ, 1, 1, O_LW); push(S_MEM_WB, rnd(), 1, O_LW);
        push(S_FETCH, 0, 1, O_LW);
        i = 1;
        while (q.size() > 0) begin
            e = q.pop_front(); rdy1 = e.rdy;
            @(negedge clk); got = obs1(); n_checks++;
            if (got !== e.exp) $display("FAIL rst_mid_post cyc%0d: got %h exp %h", i, got, e.exp);
            else n_pass++;
            @(posedge clk); #1; i++;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_back_to_back();
        test_branch();
        test_jump();
        test_fetch_wait();
        test_sw_wait();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
